// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer
// Run controller for a Bambu-generated HLS accelerator that uses the
// start_port/done_port protocol. For each run in a campaign it holds the
// accelerator in reset, pulses start, counts cycles until done (or until the
// watchdog fires), and reports a per-run result. It also keeps min/max/total
// statistics over the runs that completed.
//
// Ports
//   clock, reset        system clock (rising edge), async active-low reset
//   go, num_runs        campaign request (accepted only in IDLE) and run count
//   dut_reset           active-low reset driven to the accelerator
//   dut_start_port      one-cycle start pulse to the accelerator
//   dut_done_port       done pulse from the accelerator (sampled only in RUN)
//   busy                high from the accepted go until the return to IDLE
//   res_valid/res_ready per-run result handshake
//   res_idx, res_cycles, res_timeout   per-run result fields
//   min_cycles, max_cycles, total_cycles   aggregate stats of completed runs
//   finished            one-cycle pulse at the end of a campaign
//   fsm_state           current controller state, for observation only
//
// Result handshake: res_valid rises when a run result is latched and stays
// high, with res_idx/res_cycles/res_timeout held stable, until a cycle in
// which res_valid and res_ready are both high. That cycle is the transfer;
// res_valid is low on the following cycle. res_ready may be high at any time
// and has no effect while res_valid is low.
module hls_run_sequencer #(
    parameter int CNT_W      = 32,
    parameter int TOT_W      = 48,
    parameter int RUN_W      = 16,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 200000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [RUN_W-1:0] num_runs,
    output logic             dut_reset,
    output logic             dut_start_port,
    input  logic             dut_done_port,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RUN_W-1:0] res_idx,
    output logic [CNT_W-1:0] res_cycles,
    output logic             res_timeout,
    output logic [CNT_W-1:0] min_cycles,
    output logic [CNT_W-1:0] max_cycles,
    output logic [TOT_W-1:0] total_cycles,
    output logic             finished,
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRST   = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam int             RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

    state_t           state, state_nx;
    logic [RC_W-1:0]  rst_cnt;
    logic [CNT_W-1:0] cnt;
    logic [RUN_W-1:0] run_idx;
    logic [RUN_W-1:0] runs_lat;
    logic             dut_reset_r;
    logic             timeout_hit;
    logic             last_run;
    logic [TOT_W:0]   total_sum;
    logic [TOT_W-1:0] total_sat;

    // The watchdog compares against the live count; cnt never passes
    // TIMEOUT while it is enabled because the run ends on equality.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TMO_VAL);
    assign last_run    = (run_idx == (runs_lat - RUN_W'(1)));

    // One extra bit catches the carry so the total sticks at all-ones.
    assign total_sum = {1'b0, total_cycles} + (TOT_W+1)'(cnt);
    assign total_sat = total_sum[TOT_W] ? {TOT_W{1'b1}} : total_sum[TOT_W-1:0];

    always_comb begin
        state_nx       = state;
        busy           = (state != S_IDLE);
        dut_start_port = (state == S_START);
        res_valid      = (state == S_REPORT);
        finished       = (state == S_FINISH);
        case (state)
            S_IDLE:   if (go) state_nx = (num_runs == '0) ? S_FINISH : S_DRST;
            S_DRST:   if (rst_cnt == RC_LAST) state_nx = S_START;
            S_START:  state_nx = S_RUN;
            S_RUN:    if (dut_done_port || timeout_hit) state_nx = S_REPORT;
            S_REPORT: if (res_ready) state_nx = (res_timeout || last_run) ? S_FINISH : S_DRST;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // dut_reset is registered from the next state so it is low exactly
    // during DRST cycles, yet still reads 0 while the controller is in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            dut_reset_r <= 1'b0;
        end else begin
            state       <= state_nx;
            dut_reset_r <= (state_nx != S_DRST);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_cnt      <= '0;
            cnt          <= '0;
            run_idx      <= '0;
            runs_lat     <= '0;
            res_cycles   <= '0;
            res_timeout  <= 1'b0;
            min_cycles   <= '1;
            max_cycles   <= '0;
            total_cycles <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        runs_lat     <= num_runs;
                        run_idx      <= '0;
                        rst_cnt      <= '0;
                        res_timeout  <= 1'b0;
                        min_cycles   <= '1;
                        max_cycles   <= '0;
                        total_cycles <= '0;
                    end
                end
                S_DRST:  rst_cnt <= rst_cnt + RC_W'(1);
                S_START: cnt <= CNT_W'(1);
                S_RUN: begin
                    // done takes priority over a watchdog hit in the same cycle
                    if (dut_done_port) begin
                        res_cycles   <= cnt;
                        res_timeout  <= 1'b0;
                        if (cnt < min_cycles) min_cycles <= cnt;
                        if (cnt > max_cycles) max_cycles <= cnt;
                        total_cycles <= total_sat;
                    end else if (timeout_hit) begin
                        res_cycles  <= TMO_VAL;
                        res_timeout <= 1'b1;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_REPORT: begin
                    if (res_ready && !(res_timeout || last_run)) begin
                        run_idx <= run_idx + RUN_W'(1);
                        rst_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_reset = dut_reset_r;
    assign res_idx   = run_idx;
    assign fsm_state = state;

endmodule

// File: tb/tb_hls_run_sequencer.sv
module tb_hls_run_sequencer;

  localparam int CNT_W      = 32;
  localparam int TOT_W      = 48;
  localparam int RUN_W      = 16;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 20;

  logic             clock;
  logic             reset;
  logic             go;
  logic [RUN_W-1:0] num_runs;
  logic             dut_reset;
  logic             dut_start_port;
  logic             dut_done_port = 1'b0;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [RUN_W-1:0] res_idx;
  logic [CNT_W-1:0] res_cycles;
  logic             res_timeout;
  logic [CNT_W-1:0] min_cycles;
  logic [CNT_W-1:0] max_cycles;
  logic [TOT_W-1:0] total_cycles;
  logic             finished;
  logic [2:0]       fsm_state;

  hls_run_sequencer #(
    .CNT_W(CNT_W), .TOT_W(TOT_W), .RUN_W(RUN_W),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .num_runs(num_runs),
    .dut_reset(dut_reset), .dut_start_port(dut_start_port),
    .dut_done_port(dut_done_port), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_cycles(res_cycles), .res_timeout(res_timeout),
    .min_cycles(min_cycles), .max_cycles(max_cycles),
    .total_cycles(total_cycles), .finished(finished), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- accelerator model ----------------
  // Each start pops a latency L: done is high during RUN cycle L (L=0: never).
  int lat_q[$];
  always begin
    @(negedge clock);
    if (reset && dut_start_port) begin
      int lat;
      lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      if (lat > 0) begin
        repeat (lat) @(negedge clock);
        dut_done_port = 1'b1;
        @(negedge clock);
        dut_done_port = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitors ----------------
  logic [CNT_W:0] exp_q[$];   // {timeout, cycles}
  logic [CNT_W:0] e;
  int exp_idx, n_reports, n_starts, n_finished;
  int rlow, last_low, start_hi;

  always @(negedge clock) begin
    if (!reset) begin
      rlow = 0;
      start_hi = 0;
    end else begin
      if (!dut_reset) rlow++;
      else begin
        if (rlow != 0) last_low = rlow;
        rlow = 0;
      end
      if (dut_start_port) begin
        start_hi++;
        if (start_hi == 1) begin
          n_starts++;
          check("drst_low_len", last_low, RST_CYCLES);
        end
      end else if (start_hi != 0) begin
        check("start_width", start_hi, 1);
        start_hi = 0;
      end
      if (finished) n_finished++;
      if (res_valid && res_ready) begin
        n_reports++;
        check("report_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_cycles", res_cycles, e[CNT_W-1:0]);
          check("res_timeout", res_timeout, e[CNT_W]);
          check("res_idx", res_idx, exp_idx);
          exp_idx++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    exp_idx = 0; n_reports = 0; n_starts = 0; n_finished = 0;
  endtask

  task automatic do_go(input int n);
    @(posedge clock); #1;
    num_runs = RUN_W'(n);
    go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
  endtask

  task automatic wait_finished(input string tag, input int budget, output int k);
    k = 0;
    while (!finished && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, k < budget, 1);
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_signal_valid(input int budget);
    int k;
    k = 0;
    while (!res_valid && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("res_valid_seen", k < budget, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int k;
    reset = 1'b0; go = 1'b0; num_runs = '0; res_ready = 1'b1;
    last_low = 0;
    clear_counts();
    repeat (3) @(negedge clock);
    check("rst_dut_reset", dut_reset, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_start", dut_start_port, 0);
    check("rst_finished", finished, 0);
    check("rst_min", min_cycles, {CNT_W{1'b1}});
    check("rst_max", max_cycles, 0);
    check("rst_total", total_cycles, 0);
    check("rst_res_idx", res_idx, 0);
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_dut_reset", dut_reset, 1);

    // single run, done 10 cycles after start
    clear_counts();
    lat_q.push_back(10);
    exp_q.push_back({1'b0, CNT_W'(10)});
    do_go(1);
    wait_finished("t1_finish", 200, k);
    check("t1_reports", n_reports, 1);
    check("t1_finished_pulses", n_finished, 1);
    check("t1_min", min_cycles, 10);
    check("t1_max", max_cycles, 10);
    check("t1_total", total_cycles, 10);
    check("t1_busy", busy, 0);

    // three runs 5,9,7; a second go mid-campaign must be ignored
    clear_counts();
    lat_q.push_back(5); lat_q.push_back(9); lat_q.push_back(7);
    exp_q.push_back({1'b0, CNT_W'(5)});
    exp_q.push_back({1'b0, CNT_W'(9)});
    exp_q.push_back({1'b0, CNT_W'(7)});
    do_go(3);
    repeat (6) @(negedge clock);
    check("t2_busy", busy, 1);
    do_go(5);
    wait_finished("t2_finish", 300, k);
    check("t2_reports", n_reports, 3);
    check("t2_starts", n_starts, 3);
    check("t2_min", min_cycles, 5);
    check("t2_max", max_cycles, 9);
    check("t2_total", total_cycles, 21);
    check("t2_pending", exp_q.size(), 0);

    // watchdog: accelerator never finishes, campaign aborts after first run
    clear_counts();
    lat_q.push_back(0);
    exp_q.push_back({1'b1, CNT_W'(TIMEOUT)});
    do_go(4);
    wait_finished("t3_finish", 300, k);
    check("t3_reports", n_reports, 1);
    check("t3_starts", n_starts, 1);
    check("t3_min", min_cycles, {CNT_W{1'b1}});
    check("t3_max", max_cycles, 0);
    check("t3_total", total_cycles, 0);

    // back-pressure: res_ready low for 6 cycles in REPORT
    clear_counts();
    res_ready = 1'b0;
    lat_q.push_back(4); lat_q.push_back(6);
    exp_q.push_back({1'b0, CNT_W'(4)});
    exp_q.push_back({1'b0, CNT_W'(6)});
    do_go(2);
    wait_signal_valid(100);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("t4_hold_valid", res_valid, 1);
      check("t4_hold_cycles", res_cycles, 4);
      check("t4_hold_idx", res_idx, 0);
      check("t4_hold_dut_reset", dut_reset, 1);
    end
    @(posedge clock); #1 res_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("t4_valid_drop", res_valid, 0);
    check("t4_drst_after_hs", dut_reset, 0);
    wait_finished("t4_finish", 200, k);
    check("t4_reports", n_reports, 2);
    check("t4_min", min_cycles, 4);
    check("t4_total", total_cycles, 10);

    // zero runs: immediate finish, no start
    clear_counts();
    do_go(0);
    wait_finished("t5_finish", 3, k);
    check("t5_latency", k <= 2, 1);
    check("t5_starts", n_starts, 0);
    check("t5_reports", n_reports, 0);

    // reset asserted mid-RUN
    clear_counts();
    lat_q.push_back(0);
    do_go(1);
    k = 0;
    while (!dut_start_port && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("t6_start_seen", k < 50, 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("t6_state", fsm_state, 0);
    check("t6_dut_reset", dut_reset, 0);
    check("t6_busy", busy, 0);
    check("t6_res_cycles", res_cycles, 0);
    check("t6_min", min_cycles, {CNT_W{1'b1}});
    check("t6_total", total_cycles, 0);
    @(posedge clock); #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("t6_idle_dut_reset", dut_reset, 1);
    check("t6_idle_busy", busy, 0);
    check("t6_reports", n_reports, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
